// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 convolution engine: the sequencing state
// encoding used by conv2d_ctrl and the MAC pipeline depth, which also sizes
// the datapath's stage-valid vector.
// -----------------------------------------------------------------------------
package conv_pkg;

    // Sequencing states of the convolution controller.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Number of MAC pipeline stages between window issue and conv result.
    localparam int PIPE_DEPTH = 4;

    // Width of the position counters handed to the line buffer.
    localparam int CNT_W = 32;

    // Pixel index of the last flush cycle: WIDTH*WIDTH real pixels followed
    // by WIDTH+1 zero pixels, counted from 0.
    function automatic int unsigned last_flush_index(input int unsigned width);
        return width * width + width;
    endfunction

endpackage

// File: rtl/pos_counter.sv
// -----------------------------------------------------------------------------
// pos_counter
// Column/row position counter for a raster of WIDTH columns. The column
// advances on every enabled cycle and wraps WIDTH-1 -> 0, advancing the row
// on the wrap. The row is not bounded, so callers may run past the last
// frame row (used for flushing a line buffer).
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset, clears both counters
//   clear   in   synchronous clear to (0,0); wins over enable
//   enable  in   advance one position this cycle
//   col     out  current column
//   row     out  current row
// -----------------------------------------------------------------------------
module pos_counter
    import conv_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv2d_ctrl.sv
// -----------------------------------------------------------------------------
// conv2d_ctrl
// Sequencing controller for one 3x3 convolution engine over a WIDTH x WIDTH
// single-channel frame. It accepts pixels over a valid/ready handshake, drives
// the padding line buffer's write strobe and position counters, flushes the
// line buffer with WIDTH+1 zero pixels after the last real pixel, issues one
// window per output pixel and walks it through the MAC pipeline's stage-valid
// vector, and pulses frame_done once the last result leaves the pipeline.
//
// Ports
//   clk                  in   rising-edge clock
//   rst                  in   synchronous active-high reset
//   start                in   begin a frame (honoured only when idle)
//   in_valid             in   upstream pixel present
//   in_ready             out  pixel is accepted this cycle when in_valid=1
//   valid_in             out  line-buffer write strobe (combinational)
//   pad_zero             out  datapath forces line-buffer input pixel to 0
//   counter_col          out  column of the pixel written this cycle
//   counter_row          out  row of the pixel written this cycle
//   valid_in_pipeline2D  out  window at line-buffer outputs enters pipeline
//   valid_pipeline2D     out  per-stage valid of the MAC pipeline
//   out_valid            out  conv result valid at datapath output
//   busy                 out  high whenever not idle
//   frame_done           out  one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module conv2d_ctrl
    import conv_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  valid_in,
    output logic                  pad_zero,
    output logic [CNT_W-1:0]      counter_col,
    output logic [CNT_W-1:0]      counter_row,
    output logic                  valid_in_pipeline2D,
    output logic [PIPE_DEPTH-1:0] valid_pipeline2D,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(WIDTH * WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(last_flush_index(WIDTH));
    // The first complete 3x3 window is available once the pixel at
    // (row 1, col 1) has been written.
    localparam logic [CNT_W-1:0] FIRST_WIN  = CNT_W'(WIDTH + 1);

    state_t           state;
    logic [CNT_W-1:0] pix_idx;
    logic             clear_pos;

    // Real pixels are written only on handshake; flush writes every cycle.
    always_comb begin
        valid_in = 1'b0;
        unique case (state)
            FILL:    valid_in = in_valid;
            FLUSH:   valid_in = 1'b1;
            default: valid_in = 1'b0;
        endcase
    end

    assign clear_pos = (state == IDLE) && start;
    assign out_valid = valid_pipeline2D[PIPE_DEPTH-1];

    pos_counter #(
        .WIDTH (WIDTH)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear_pos),
        .enable (valid_in),
        .col    (counter_col),
        .row    (counter_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            pix_idx             <= '0;
            in_ready            <= 1'b0;
            pad_zero            <= 1'b0;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
            valid_in_pipeline2D <= 1'b0;
            valid_pipeline2D    <= '0;
        end else begin
            // Window issue and stage-valid shift run every cycle, independent
            // of upstream stalls.
            valid_in_pipeline2D <= valid_in && (pix_idx >= FIRST_WIN);
            valid_pipeline2D    <= {valid_pipeline2D[PIPE_DEPTH-2:0], valid_in_pipeline2D};
            frame_done          <= 1'b0;

            if (valid_in) begin
                pix_idx <= pix_idx + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        pix_idx  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (in_valid && (pix_idx == LAST_PIXEL)) begin
                        state    <= FLUSH;
                        in_ready <= 1'b0;
                        pad_zero <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (pix_idx == LAST_FLUSH) begin
                        state    <= DRAIN;
                        pad_zero <= 1'b0;
                    end
                end
                DRAIN: begin
                    // No windows are issued in DRAIN, so once nothing is left
                    // before the second-to-last stage the pipeline empties
                    // deterministically: frame_done is raised so that it
                    // coincides with the final result at the output stage.
                    if (frame_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!valid_in_pipeline2D &&
                                 (valid_pipeline2D[PIPE_DEPTH-3:0] == '0)) begin
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    pad_zero <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv2d_ctrl
// Self-checking bench for conv2d_ctrl with WIDTH=7. A frame-level reference
// (pixel index, mode, history of line-buffer writes that carry a full window)
// predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_conv2d_ctrl;

    localparam int W  = 7;
    localparam int N  = W * W;
    localparam int HN = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        valid_in;
    logic        pad_zero;
    logic [31:0] counter_col;
    logic [31:0] counter_row;
    logic        valid_in_pipeline2D;
    logic [3:0]  valid_pipeline2D;
    logic        out_valid;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    conv2d_ctrl #(.WIDTH(W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .valid_in            (valid_in),
        .pad_zero            (pad_zero),
        .counter_col         (counter_col),
        .counter_row         (counter_row),
        .valid_in_pipeline2D (valid_in_pipeline2D),
        .valid_pipeline2D    (valid_pipeline2D),
        .out_valid           (out_valid),
        .busy                (busy),
        .frame_done          (frame_done)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef enum int {M_IDLE, M_FILL, M_FLUSH, M_DRAIN} mmode_t;
    mmode_t mode    = M_IDLE;
    int     idx     = 0;      // pixels written to the line buffer this frame
    int     rb      = 0;      // history before this cycle was wiped by reset
    int     done_at = -100;
    bit     hist_w[HN];       // cycle wrote a pixel that completes a window
    int     n_win, n_out, n_done;
    bit     saw_done;

    function automatic bit hw(input int i);
        if (i < 0 || i < rb || i >= HN) return 1'b0;
        return hist_w[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle reference check plus model advance for the current cycle.
    task automatic model_step();
        logic        e_ready, e_vin, e_pad, e_vip, e_out, e_busy, e_done;
        logic [3:0]  e_vp;
        logic [10:0] ev, av;
        e_ready = (mode == M_FILL);
        e_vin   = (mode == M_FILL) ? in_valid : (mode == M_FLUSH);
        e_pad   = (mode == M_FLUSH);
        e_vip   = hw(cyc - 1);
        for (int k = 0; k < 4; k++) e_vp[k] = hw(cyc - 2 - k);
        e_out   = e_vp[3];
        e_busy  = (mode != M_IDLE);
        e_done  = (mode == M_DRAIN) && (cyc == done_at);
        ev = {e_ready, e_vin, e_pad, e_vip, e_vp, e_out, e_busy, e_done};
        av = {in_ready, valid_in, pad_zero, valid_in_pipeline2D, valid_pipeline2D,
              out_valid, busy, frame_done};
        chk("ctrl", 32'(av), 32'(ev));
        chk("col", counter_col, 32'(idx % W));
        chk("row", counter_row, 32'(idx / W));

        n_win    += int'(valid_in_pipeline2D);
        n_out    += int'(out_valid);
        n_done   += int'(frame_done);
        saw_done  = frame_done;

        if (cyc < HN) hist_w[cyc] = e_vin && (idx >= W + 1);

        if (rst) begin
            mode = M_IDLE;
            idx  = 0;
            rb   = cyc + 1;
        end else begin
            case (mode)
                M_IDLE:  if (start) begin mode = M_FILL; idx = 0; end
                M_FILL:  if (in_valid) begin
                             idx++;
                             if (idx == N) mode = M_FLUSH;
                         end
                M_FLUSH: begin
                             idx++;
                             if (idx == N + W + 1) begin
                                 mode    = M_DRAIN;
                                 done_at = cyc + 5;
                             end
                         end
                M_DRAIN: if (cyc == done_at) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        saw_done = 1'b0;
        while (!saw_done && t < budget) begin
            tick();
            t++;
        end
        if (!saw_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_done_timeout cyc=%0d got=none want=pulse", cyc);
        end
    endtask

    task automatic clear_counts();
        n_win = 0; n_out = 0; n_done = 0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_windows"}, 32'(n_win), 32'(N));
        chk({tag, "_outputs"}, 32'(n_out), 32'(N));
        chk({tag, "_done"},    32'(n_done), 32'd1);
    endtask

    initial begin
        int s;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        repeat (3) tick();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_vec",   32'({in_ready, valid_in, pad_zero, valid_in_pipeline2D,
                              valid_pipeline2D, out_valid, frame_done}), 32'd0);
        chk("rst_cnt",   counter_col | counter_row, 32'd0);
        rst = 1'b0;
        tick();

        // in_valid while idle is not accepted
        in_valid = 1'b1;
        #1;
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_vin",   32'(valid_in), 32'd0);
        repeat (2) tick();
        in_valid = 1'b0;
        tick();

        // Frame A: no stalls, directed timing
        clear_counts();
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("A_fill_ready", 32'(in_ready), 32'd1);
        chk("A_first_pos",  counter_col | counter_row, 32'd0);
        in_valid = 1'b1;
        run_to(s + 9);
        chk("A_pix11_col", counter_col, 32'd1);
        chk("A_pix11_row", counter_row, 32'd1);
        chk("A_no_win_yet", 32'(valid_in_pipeline2D), 32'd0);
        run_to(s + 10);
        chk("A_first_win", 32'(valid_in_pipeline2D), 32'd1);
        run_to(s + 11);
        chk("A_stage0", 32'(valid_pipeline2D), 32'b0001);
        run_to(s + 14);
        chk("A_first_out", 32'(out_valid), 32'd1);
        run_to(s + 50);
        chk("A_flush_pad", 32'(pad_zero), 32'd1);
        chk("A_flush_pos", {counter_row[15:0], counter_col[15:0]}, {16'd7, 16'd0});
        run_to(s + 57);
        chk("A_flush_last", {counter_row[15:0], counter_col[15:0]}, {16'd8, 16'd0});
        chk("A_flush_pad_last", 32'(pad_zero), 32'd1);
        run_to(s + 62);
        chk("A_done_time", 32'({frame_done, busy}), 32'b11);
        run_to(s + 63);
        chk("A_idle_after", 32'({frame_done, busy}), 32'b00);
        in_valid = 1'b0;
        tick();
        chk_counts("A");

        // Frame B: random gaps, start pulsed mid-FILL and in DRAIN
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && mode == M_FILL; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            start    = (i == 20);
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && mode != M_DRAIN; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40);
        tick();
        chk_counts("B");

        // Frame C: reset after 20 pixels
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && idx < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("C_rst_vec", 32'({in_ready, valid_in, pad_zero, valid_in_pipeline2D,
                              valid_pipeline2D, out_valid, busy, frame_done}), 32'd0);
        chk("C_rst_cnt", counter_col | counter_row, 32'd0);
        repeat (6) tick();
        chk("C_no_done", 32'(n_done), 32'd0);

        // Frame D: clean full frame after reset
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("D_first_pos", counter_col | counter_row, 32'd0);
        in_valid = 1'b1;
        wait_done(120);
        in_valid = 1'b0;
        tick();
        chk_counts("D");

        // Frames E and F back-to-back: start in the cycle after frame_done
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        wait_done(120);
        chk_counts("E");
        clear_counts();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("F_restart_ready", 32'(in_ready), 32'd1);
        wait_done(120);
        in_valid = 1'b0;
        repeat (3) tick();
        chk_counts("F");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
